// File: rtl/pmod_enc_multi_core.sv
// pmod_enc_multi_core
//   Multi-channel quadrature rotary-encoder core for the slot bus. Each
//   channel has A/B/button/switch inputs. Every input goes through a 2-FF
//   synchroniser and then a debouncer. Each channel has a quadrature decoder
//   that drives a signed position counter. The core also keeps sticky W1C
//   event flags.
//
// Ports
//   clk, reset          : system clock, asynchronous active-high reset
//   cs, read, write     : slot select and strobes (read has no side effects)
//   addr[4:0]           : register address
//   wr_data[31:0]       : write data
//   rd_data[31:0]       : combinational read mux of registered state
//   enc_a/enc_b[N_CH]   : quadrature inputs (asynchronous)
//   enc_btn/enc_sw[N_CH]: push-button and slide switch (asynchronous)
//
// Register map
//   0   R    debounced levels, nibble i = {sw, btn, b, a}
//   1   W1C  flags: [i] CW, [8+i] CCW, [16+i] button rise, [24+i] illegal
//   2+i R/W  position counter i (read sign-extended)
//   8   R/W  control: [N_CH-1:0] enable, [16] x4 mode, [17] saturate
module pmod_enc_multi_core #(
  parameter int N_CH      = 2,
  parameter int DB_CYCLES = 100000,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            read,
  input  logic            write,
  input  logic [4:0]      addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  input  logic [N_CH-1:0] enc_a,
  input  logic [N_CH-1:0] enc_b,
  input  logic [N_CH-1:0] enc_btn,
  input  logic [N_CH-1:0] enc_sw
);

  localparam int NI       = 4 * N_CH;
  localparam int DB_W     = $clog2(DB_CYCLES + 1);
  localparam int ARM_LAST = DB_CYCLES + 3;
  localparam int ARM_W    = $clog2(ARM_LAST + 1);
  localparam logic [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  // The read strobe has no side effects.
  logic unused_read;
  assign unused_read = read;

  // Inputs packed as one nibble per channel, {sw, btn, b, a}, so that the
  // debounced vector is also the level register read at address 0.
  logic [NI-1:0] raw_in, sync1, sync2, db;
  logic [DB_W-1:0] db_cnt [NI];

  always_comb begin
    raw_in = '0;
    for (int i = 0; i < N_CH; i++)
      raw_in[4*i +: 4] = {enc_sw[i], enc_btn[i], enc_b[i], enc_a[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // The debounced level changes only after the synchronised value has
  // differed from it for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= '0;
      for (int j = 0; j < NI; j++) db_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < NI; j++) begin
        if (sync2[j] == db[j]) begin
          db_cnt[j] <= '0;
        end else if (db_cnt[j] == DB_W'(DB_CYCLES - 1)) begin
          db[j]     <= sync2[j];
          db_cnt[j] <= '0;
        end else begin
          db_cnt[j] <= db_cnt[j] + 1'b1;
        end
      end
    end
  end

  // Startup arming. The decoders and button edge detectors stay quiet until
  // inputs that idle high have had time to reach their debounced level.
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  assign armed = (arm_cnt == ARM_W'(ARM_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 1'b1;
  end

  // Control register.
  logic [N_CH-1:0] ctrl_en;
  logic            ctrl_x4, ctrl_sat;
  logic            wr_en;
  assign wr_en = cs && write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en  <= '1;
      ctrl_x4  <= 1'b0;
      ctrl_sat <= 1'b0;
    end else if (wr_en && addr == 5'd8) begin
      ctrl_en  <= wr_data[N_CH-1:0];
      ctrl_x4  <= wr_data[16];
      ctrl_sat <= wr_data[17];
    end
  end

  // Per-channel decode. Only the previous state is tracked while disarmed.
  logic [1:0]      prev_ab [N_CH];
  logic [N_CH-1:0] prev_btn;
  logic [N_CH-1:0] cnt_up, cnt_dn, illegal, btn_rise;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      logic [1:0] cur;
      logic       cw, ccw, hit;
      cur = {db[4*i], db[4*i+1]};
      cw  = (prev_ab[i] == 2'b00 && cur == 2'b10) ||
            (prev_ab[i] == 2'b10 && cur == 2'b11) ||
            (prev_ab[i] == 2'b11 && cur == 2'b01) ||
            (prev_ab[i] == 2'b01 && cur == 2'b00);
      ccw = (prev_ab[i] == 2'b00 && cur == 2'b01) ||
            (prev_ab[i] == 2'b01 && cur == 2'b11) ||
            (prev_ab[i] == 2'b11 && cur == 2'b10) ||
            (prev_ab[i] == 2'b10 && cur == 2'b00);
      // x1 mode counts one step per detent: the transitions into 00.
      hit = ctrl_x4 || (cur == 2'b00);
      cnt_up[i]   = armed && ctrl_en[i] && cw  && hit;
      cnt_dn[i]   = armed && ctrl_en[i] && ccw && hit;
      illegal[i]  = armed && ((prev_ab[i] ^ cur) == 2'b11);
      btn_rise[i] = armed && db[4*i+2] && !prev_btn[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_btn <= '0;
      for (int i = 0; i < N_CH; i++) prev_ab[i] <= 2'b00;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        prev_ab[i]  <= {db[4*i], db[4*i+1]};
        prev_btn[i] <= db[4*i+2];
      end
    end
  end

  // Sticky flags. A new event in the same cycle as a W1C keeps the bit set.
  logic [31:0] flags, flag_set, flag_clr;

  always_comb begin
    flag_set = '0;
    for (int i = 0; i < N_CH; i++) begin
      flag_set[i]      = cnt_up[i];
      flag_set[8+i]    = cnt_dn[i];
      flag_set[16+i]   = btn_rise[i];
      flag_set[24+i]   = illegal[i];
    end
    flag_clr = (wr_en && addr == 5'd1) ? wr_data : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags <= '0;
    else       flags <= (flags & ~flag_clr) | flag_set;
  end

  // Position counters. A bus load takes priority over a step in the same cycle.
  logic [CNT_W-1:0] pos [N_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) pos[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_en && addr == 5'(2 + i)) begin
          pos[i] <= wr_data[CNT_W-1:0];
        end else if (cnt_up[i]) begin
          if (!(ctrl_sat && pos[i] == POS_MAX)) pos[i] <= pos[i] + 1'b1;
        end else if (cnt_dn[i]) begin
          if (!(ctrl_sat && pos[i] == POS_MIN)) pos[i] <= pos[i] - 1'b1;
        end
      end
    end
  end

  // Read mux.
  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0: rd_data = 32'(db);
      5'd1: rd_data = flags;
      5'd8: begin
        rd_data[N_CH-1:0] = ctrl_en;
        rd_data[16]       = ctrl_x4;
        rd_data[17]       = ctrl_sat;
      end
      default: begin
        for (int i = 0; i < N_CH; i++)
          if (addr == 5'(2 + i)) rd_data = 32'($signed(pos[i]));
      end
    endcase
  end

endmodule
